// File: rtl/spi_master_lbus.sv
// spi_master_lbus
// SPI initiator (CPOL=0, CPHA=0) that sends one 24-bit register frame per host
// command to an AD9643-style SPI/local-bus slave. The frame is
// {R/W, A14..A0, D7..D0}, MSB first, and R/W=1 means read.
//
// Parameters:
//   CLK_DIV  clk cycles per sclk half-period (2..255)
//   CSB_GAP  minimum clk cycles csb stays high between frames (>= 1)
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_ready is high only in IDLE
//   cmd_rw/addr/wdata       command fields, sampled only when a command is accepted
//   rsp_valid               one-cycle strobe when a frame ends
//   rsp_rdata               last read byte, held until the next read completes
//   sclk, csb, mosi, miso   SPI pins
//   sdio_oe                 3-wire pad direction (1 = master drives SDIO); present
//                           only when SPI_MASTER_3WIRE_EN is defined
//
// Optional feature macro: SPI_MASTER_3WIRE_EN
module spi_master_lbus #(
  parameter int CLK_DIV = 4,
  parameter int CSB_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [14:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        sclk,
  output logic        csb,
  output logic        mosi,
  input  logic        miso
`ifdef SPI_MASTER_3WIRE_EN
  ,
  output logic        sdio_oe
`endif
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_lbus: CLK_DIV must be in 2..255");
  end
  if (CSB_GAP < 1) begin : g_bad_csb_gap
    $error("spi_master_lbus: CSB_GAP must be >= 1");
  end

  // One counter serves both the sclk half-periods and the csb gap, so it is
  // sized for whichever of the two is longer.
  localparam int CNT_MAX = (CLK_DIV > CSB_GAP) ? CLK_DIV : CSB_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CSB_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          phase;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic          rw_q;
  logic [7:0]    rx;

  logic accept;
  logic half_done;
  logic gap_done;
  logic sclk_rise;
  logic bit_end;

  assign accept    = cmd_valid && (state == IDLE);
  assign half_done = (cnt == HALF_LAST);
  assign gap_done  = (cnt == GAP_LAST);
  // phase=0 is the sclk-low half of a bit, phase=1 the high half. sclk is
  // decoded from phase, so the edge that ends a low half is the edge on which
  // sclk rises, and the edge that ends a high half is the one where it falls.
  assign sclk_rise = (state == SHIFT) && half_done && !phase;
  assign bit_end   = (state == SHIFT) && half_done && phase;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (half_done) state_nxt = SHIFT;
      SHIFT:   if (bit_end && bit_cnt == 5'd23) state_nxt = HOLD;
      HOLD:    if (half_done) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timing counter, shift/capture registers and the response byte. The shift
  // register moves only at the end of a high half, so mosi changes only as
  // sclk falls. For reads the data byte is loaded as zero, which keeps mosi
  // low during bits 16..23 without any extra gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      phase     <= 1'b0;
      bit_cnt   <= 5'd0;
      shreg     <= 24'h000000;
      rw_q      <= 1'b0;
      rx        <= 8'h00;
      rsp_rdata <= 8'h00;
    end else begin
      if (state == IDLE || state_nxt != state) cnt <= '0;
      else if (state != GAP && half_done)      cnt <= '0;
      else                                     cnt <= cnt + CW'(1);

      if (state == SHIFT && half_done) phase <= ~phase;

      if (accept) begin
        shreg   <= {cmd_rw, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
        rw_q    <= cmd_rw;
        bit_cnt <= 5'd0;
      end else if (bit_end) begin
        shreg   <= {shreg[22:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (sclk_rise && bit_cnt >= 5'd16) rx <= {rx[6:0], miso};

      if (state == HOLD && half_done && rw_q) rsp_rdata <= rx;
    end
  end

  // Pin and handshake decode. rsp_valid is the first GAP cycle, which is the
  // same cycle csb returns high and rsp_rdata shows the new read byte.
  always_comb begin
    cmd_ready = 1'b0;
    csb       = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:  cmd_ready = 1'b1;
      SETUP: begin
        csb  = 1'b0;
        mosi = shreg[23];
      end
      SHIFT: begin
        csb  = 1'b0;
        sclk = phase;
        mosi = shreg[23];
      end
      HOLD: begin
        csb  = 1'b0;
        mosi = shreg[23];
      end
      GAP:   rsp_valid = (cnt == '0);
      default: ;
    endcase
  end

`ifdef SPI_MASTER_3WIRE_EN
  // On a read the pad is released from the low half of bit 16 (bit_cnt has
  // just become 16) through HOLD, and taken back as csb rises.
  always_comb begin
    sdio_oe = !(rw_q && ((state == SHIFT && bit_cnt >= 5'd16) || state == HOLD));
  end
`endif

endmodule

// File: tb/tb_spi_master_lbus.sv
// tb_spi_master_lbus
// Self-checking bench for spi_master_lbus. Two instances run side by side:
// unit 0 with CLK_DIV=4/CSB_GAP=4 and unit 1 with CLK_DIV=2/CSB_GAP=1.
// A clk-sampled slave model decodes each frame, serves read bytes on miso
// and stores written bytes, so writes can be read back.
module tb_spi_master_lbus;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]       cmd_valid = 2'b00;
  logic [1:0]       cmd_rw = 2'b00;
  logic [1:0][14:0] cmd_addr = '0;
  logic [1:0][7:0]  cmd_wdata = '0;
  wire  [1:0]       cmd_ready;
  wire  [1:0]       rsp_valid;
  wire  [1:0][7:0]  rsp_rdata;
  wire  [1:0]       sclk;
  wire  [1:0]       csb;
  wire  [1:0]       mosi;
  logic [1:0]       miso_q = 2'b00;
`ifdef SPI_MASTER_3WIRE_EN
  wire  [1:0]       sdio_oe;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_master_lbus #(
      .CLK_DIV(g == 0 ? 4 : 2),
      .CSB_GAP(g == 0 ? 4 : 1)
    ) u_dut (
`ifdef SPI_MASTER_3WIRE_EN
      .sdio_oe  (sdio_oe[g]),
`endif
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_rw   (cmd_rw[g]),
      .cmd_addr (cmd_addr[g]),
      .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .sclk     (sclk[g]),
      .csb      (csb[g]),
      .mosi     (mosi[g]),
      .miso     (miso_q[g])
    );
  end

  // Slave model state, one entry per unit
  int          rise_cnt [2]      = '{0, 0};
  int          sclk_hi [2]       = '{0, 0};
  int          bad_edges [2]     = '{0, 0};
  int          mosi_unstable [2] = '{0, 0};
  logic        mosi_at_rise [2]  = '{1'b0, 1'b0};
  logic [23:0] mosi_word [2]     = '{24'h0, 24'h0};
  logic [15:0] wr_instr [2]      = '{16'h0, 16'h0};
  logic [7:0]  wr_data [2]       = '{8'h0, 8'h0};
  logic [7:0]  slave_byte [2]    = '{8'h0, 8'h0};
  logic [7:0]  mem [2][256];
  logic [1:0]  sclk_prev = 2'b00;
  logic [1:0]  csb_prev  = 2'b11;
  logic [1:0]  use_preset = 2'b00;
  logic [7:0]  preset_byte [2] = '{8'h0, 8'h0};

  // Slave model, sampled mid-cycle on the falling clk edge. It assembles the
  // 24 bits seen at sclk rises, stores completed writes, and shifts out the
  // read byte on sclk falls so it is settled before each rise of bits 16..23.
  // It also counts sclk activity while csb is high and mosi movement inside
  // a high half.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!csb[u] && csb_prev[u]) begin
        rise_cnt[u]  = 0;
        mosi_word[u] = 24'h0;
        sclk_hi[u]   = 0;
      end
      if (csb[u] && !csb_prev[u] && rise_cnt[u] == 24 && !mosi_word[u][23]) begin
        wr_instr[u] = mosi_word[u][23:8];
        wr_data[u]  = mosi_word[u][7:0];
        mem[u][mosi_word[u][15:8]] = mosi_word[u][7:0];
      end
      if (sclk[u]) begin
        if (csb[u]) bad_edges[u]++;
        sclk_hi[u]++;
        if (!sclk_prev[u]) begin
          mosi_word[u]    = {mosi_word[u][22:0], mosi[u]};
          rise_cnt[u]++;
          mosi_at_rise[u] = mosi[u];
        end else if (mosi[u] != mosi_at_rise[u]) begin
          mosi_unstable[u]++;
        end
      end else if (sclk_prev[u]) begin
        if (rise_cnt[u] == 16)
          slave_byte[u] = use_preset[u] ? preset_byte[u] : mem[u][mosi_word[u][7:0]];
        if (rise_cnt[u] >= 16 && rise_cnt[u] < 24)
          miso_q[u] = slave_byte[u][3'(23 - rise_cnt[u])];
        else
          miso_q[u] = 1'b0;
      end
      sclk_prev[u] = sclk[u];
      csb_prev[u]  = csb[u];
    end
  end

  typedef struct {
    int          u;
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        preload;
    logic [7:0]  slave_data;
    logic [23:0] exp_mosi;
    logic [7:0]  exp_rdata;
    int          exp_rsp;
    int          exp_ready;
    int          exp_sclk_hi;
  } vec_t;

  typedef struct {
    int         csb_fall;
    int         rsp_cyc;
    int         rsp_cnt;
    logic [7:0] rsp_data;
    logic [7:0] held_data;
    int         ready_cyc;
    int         oe_low;
    int         oe_first;
  } meas_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one command on unit v.u. Cycle 1 is the cycle after the accept edge;
  // the command fields are scrambled right after acceptance so anything
  // sampled later than the accept edge would corrupt the frame.
  task automatic applyStimulus(input vec_t v, output meas_t m);
    int u;
    u = v.u;
    m.csb_fall = -1; m.rsp_cyc = -1; m.rsp_cnt = 0; m.rsp_data = 8'h00;
    m.held_data = 8'h00; m.ready_cyc = -1; m.oe_low = 0; m.oe_first = -1;
    use_preset[u]  = v.preload;
    preset_byte[u] = v.slave_data;
    cmd_rw[u]      = v.rw;
    cmd_addr[u]    = v.addr;
    cmd_wdata[u]   = v.wdata;
    for (int k = 0; k < 1000 && !cmd_ready[u]; k++) begin
      @(posedge clk); #1;
    end
    cmd_valid[u] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0;
    cmd_rw[u]    = ~v.rw;
    cmd_addr[u]  = ~v.addr;
    cmd_wdata[u] = ~v.wdata;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (!csb[u] && m.csb_fall < 0) m.csb_fall = cyc;
      if (rsp_valid[u]) begin
        m.rsp_cnt++;
        if (m.rsp_cyc < 0) begin
          m.rsp_cyc  = cyc;
          m.rsp_data = rsp_rdata[u];
        end
      end
`ifdef SPI_MASTER_3WIRE_EN
      if (!sdio_oe[u]) begin
        m.oe_low++;
        if (m.oe_first < 0) m.oe_first = cyc;
      end
`endif
      if (cmd_ready[u]) begin
        m.ready_cyc = cyc;
        m.held_data = rsp_rdata[u];
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t  vecs [7];
  meas_t m;

  initial begin
    int found;
    int pulses;
    int falls;
    int fall1;
    int fall2;
    int rsp_first;
    int ready_hi;
    int final_ready;
    int rsp_total;
    logic csb_last;
    int div;

    vecs[0] = '{0, 1'b0, 15'h0014, 8'h5A, 1'b1, 8'h77, 24'h00145A, 8'h00, 201, 205, 96};
    vecs[1] = '{0, 1'b1, 15'h0001, 8'hEE, 1'b1, 8'hC3, 24'h800100, 8'hC3, 201, 205, 96};
    vecs[2] = '{0, 1'b0, 15'h0022, 8'hA5, 1'b0, 8'h00, 24'h0022A5, 8'hC3, 201, 205, 96};
    vecs[3] = '{0, 1'b1, 15'h0022, 8'h00, 1'b0, 8'h00, 24'h802200, 8'hA5, 201, 205, 96};
    vecs[4] = '{1, 1'b1, 15'h0003, 8'h00, 1'b1, 8'hFF, 24'h800300, 8'hFF, 101, 102, 48};
    vecs[5] = '{1, 1'b1, 15'h0004, 8'h00, 1'b1, 8'h00, 24'h800400, 8'h00, 101, 102, 48};
    vecs[6] = '{1, 1'b0, 15'h7FFF, 8'h81, 1'b1, 8'h3C, 24'h7FFF81, 8'h00, 101, 102, 48};

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d reset csb", u), csb[u], 1);
      checkOutput($sformatf("u%0d reset sclk", u), sclk[u], 0);
      checkOutput($sformatf("u%0d reset mosi", u), mosi[u], 0);
      checkOutput($sformatf("u%0d reset rsp_valid", u), rsp_valid[u], 0);
      checkOutput($sformatf("u%0d reset rsp_rdata", u), rsp_rdata[u], 0);
      checkOutput($sformatf("u%0d reset cmd_ready", u), cmd_ready[u], 1);
`ifdef SPI_MASTER_3WIRE_EN
      checkOutput($sformatf("u%0d reset sdio_oe", u), sdio_oe[u], 1);
`endif
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset during a read frame");
    cmd_rw[0] = 1'b1; cmd_addr[0] = 15'h0001; cmd_wdata[0] = 8'h00;
    use_preset[0] = 1'b1; preset_byte[0] = 8'hC3;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 500; k++) begin
      if (rise_cnt[0] >= 10 && sclk[0]) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("abort reached sclk rise 10", found, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort csb", csb[0], 1);
    checkOutput("abort sclk", sclk[0], 0);
    checkOutput("abort mosi", mosi[0], 0);
    checkOutput("abort rsp_valid", rsp_valid[0], 0);
    checkOutput("abort cmd_ready", cmd_ready[0], 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid[0]) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("abort rsp pulses", pulses, 0);
    checkOutput("abort rsp_rdata", rsp_rdata[0], 0);

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], m);
      div = (vecs[i].u == 0) ? 4 : 2;
      checkOutput($sformatf("v%0d csb_fall_cycle", i), m.csb_fall, 1);
      checkOutput($sformatf("v%0d rsp_cycle", i), m.rsp_cyc, vecs[i].exp_rsp);
      checkOutput($sformatf("v%0d rsp_count", i), m.rsp_cnt, 1);
      checkOutput($sformatf("v%0d rsp_rdata", i), m.rsp_data, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d rsp_rdata_held", i), m.held_data, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d ready_cycle", i), m.ready_cyc, vecs[i].exp_ready);
      checkOutput($sformatf("v%0d mosi_word", i), mosi_word[vecs[i].u], vecs[i].exp_mosi);
      checkOutput($sformatf("v%0d sclk_rises", i), rise_cnt[vecs[i].u], 24);
      checkOutput($sformatf("v%0d sclk_high_cycles", i), sclk_hi[vecs[i].u], vecs[i].exp_sclk_hi);
`ifdef SPI_MASTER_3WIRE_EN
      checkOutput($sformatf("v%0d oe_low_cycles", i), m.oe_low, vecs[i].rw ? 17 * div : 0);
      checkOutput($sformatf("v%0d oe_first_low", i), m.oe_first, vecs[i].rw ? 1 + 33 * div : -1);
`endif
    end
    checkOutput("loopback wr instr", wr_instr[0], 16'h0022);
    checkOutput("loopback wr data", wr_data[0], 8'hA5);

    $display("[TB] back-to-back with cmd_valid held");
    cmd_rw[0] = 1'b0; cmd_addr[0] = 15'h0005; cmd_wdata[0] = 8'h11;
    use_preset[0] = 1'b0;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    falls = 0; fall1 = -1; fall2 = -1; rsp_first = -1; rsp_total = 0;
    ready_hi = 0; final_ready = -1; csb_last = 1'b1;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      if (!csb[0] && csb_last) begin
        falls++;
        if (falls == 1) fall1 = cyc;
        if (falls == 2) begin
          fall2 = cyc;
          cmd_valid[0] = 1'b0;
        end
      end
      csb_last = csb[0];
      if (rsp_valid[0]) begin
        rsp_total++;
        if (rsp_first < 0) rsp_first = cyc;
      end
      if (cmd_ready[0]) begin
        if (falls >= 2) begin
          final_ready = cyc;
          break;
        end
        ready_hi++;
      end
      @(posedge clk); #1;
    end
    cmd_valid[0] = 1'b0;
    checkOutput("b2b first csb fall", fall1, 1);
    checkOutput("b2b first rsp", rsp_first, 201);
    checkOutput("b2b second csb fall", fall2, 206);
    checkOutput("b2b rsp count", rsp_total, 2);
    checkOutput("b2b idle ready cycles", ready_hi, 1);
    checkOutput("b2b final ready", final_ready, 410);

    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d sclk while csb high", u), bad_edges[u], 0);
      checkOutput($sformatf("u%0d mosi moved in high half", u), mosi_unstable[u], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_lbus.md
Name: spi_master_lbus

Overview:
- SPI initiator (CPOL=0, CPHA=0) that drives 24-bit single-byte register frames into the simulated AD9643 SPI/local-bus slave.
- Frame layout: 16-bit instruction {R/W, A14..A0}, then 8 data bits, all MSB first. R/W=1 means read.
- Host side: one command per frame via a valid/ready handshake, plus a one-cycle response strobe carrying read data.
- Sits in the host/testbench domain and generates sclk, csb and mosi from the system clock.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Legal range is 2..255; elaboration error outside this range.
- CSB_GAP, 4: minimum clk cycles csb stays high between frames. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE. Command is accepted on cmd_valid && cmd_ready.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  15  register address A14..A0.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse at end of frame.
- rsp_rdata  out  8  read byte; held until the next read completes; 8'h00 after reset.
- sclk  out  1  SPI clock, idle low.
- csb  out  1  SPI chip select, active low, idle high.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- sdio_oe  out  1  present only with SPI_MASTER_3WIRE_EN; 1 = master drives the SDIO pad.

Behaviour:
- Reset (async assert): state IDLE, csb=1, sclk=0, mosi=0, rsp_valid=0, rsp_rdata=8'h00, sdio_oe=1.
- cmd_ready is 1 in IDLE, including while reset is held.
- Reset mid-frame: frame is aborted immediately; no rsp_valid is ever issued for it.
- On accept, latch shift register S = {cmd_rw, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata}; all inputs are sampled only at accept.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP (CLK_DIV cycles): csb=0, sclk=0, mosi=S[23].
- SHIFT: 24 bits; each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only on sclk-low transitions and is stable throughout each high half.
  - For bits 16..23 of a read, mosi is 0.
  - miso is sampled on the clk edge where sclk rises, for bits 16..23, MSB first, into a capture register.
- HOLD (CLK_DIV cycles): sclk=0, csb=0.
- On HOLD exit:
  - csb=1, mosi=0.
  - rsp_valid=1 for exactly one cycle.
  - For reads, rsp_rdata is updated in the same cycle; for writes it is unchanged.
- GAP: CSB_GAP cycles, then IDLE.
- Timing (accept edge = cycle 0):
  - csb falls at cycle 1.
  - rsp_valid at cycle 1+50*CLK_DIV.
  - cmd_ready rises at cycle 1+50*CLK_DIV+CSB_GAP.
- cmd_valid outside IDLE is ignored (no queueing).
- A back-to-back command held valid is accepted on the first IDLE cycle.
- Exactly 24 rising sclk edges per frame; no sclk edges while csb=1.

Optional Feature:
- Macro SPI_MASTER_3WIRE_EN.
- Defined:
  - sdio_oe port exists; default is 1.
  - On a read, sdio_oe goes 0 at the start of the sclk-low half of bit 16, while mosi=0.
  - sdio_oe returns to 1 in the cycle csb rises.
  - Writes keep sdio_oe=1 for the whole frame.
- Undefined:
  - sdio_oe port is absent and mosi is always driven.
  - All other timing is identical.

Test Plan:
- Write A=15'h0014, D=8'h5A, CLK_DIV=4 -> 24 sclk rises; mosi bits = 24'h00145A MSB first; rsp_valid at cycle 201; rsp_rdata stays 8'h00.
- Read A=15'h0001, slave returns 8'hC3 -> mosi instruction 16'h8001; rsp_rdata=8'hC3 with rsp_valid; with 3WIRE_EN, sdio_oe low only during bits 16..23 plus HOLD.
- cmd_valid held high for two commands -> second csb fall at least CSB_GAP cycles after the first csb rise; cmd_ready low throughout both frames; cmd_valid pulses while busy are ignored.
- reset_n pulsed low at sclk rise #10 -> csb=1, sclk=0 on the same cycle; no rsp_valid; next command completes normally.
- CLK_DIV=2 read of 8'hFF then 8'h00 -> each sclk half-period is 2 clk; rsp_rdata = 8'hFF, then 8'h00.
- Loopback against the spi_slave_lbus model: write 8'hA5 to address 15'h0022, then read it back -> slave wr_en with wdata=8'hA5 and address 16'h0022; read returns 8'hA5.
